// File: rtl/commutator_pkg.sv
// Types and defaults shared by the commutator and decommutator lane fabric.
// No logic here; latency and backpressure belong to the modules that import it.
package commutator_pkg;
    localparam int COMM_WIDTH  = 16;
    localparam int COMM_NUM_CH = 4;

    typedef logic [$clog2(COMM_NUM_CH)-1:0] chan_t;
    typedef logic [COMM_WIDTH-1:0]          word_t;
endpackage

// File: rtl/decommutator_if.sv
// Lane-side and serial-side handshake bundle of the decommutator.
// slave = decommutator view; master = lane source and serial sink view.
interface decommutator_if
    import commutator_pkg::*;
#(
    parameter int WIDTH  = COMM_WIDTH,
    parameter int NUM_CH = COMM_NUM_CH
) ();
    logic [WIDTH-1:0]          in_data [NUM_CH-1:0];
    logic [NUM_CH-1:0]         in_valid;
    logic [NUM_CH-1:0]         in_ready;
    logic [WIDTH-1:0]          out_data;
    logic [$clog2(NUM_CH)-1:0] out_chan;
    logic                      out_last;
    logic                      out_valid;
    logic                      out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_last, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_last, out_valid
    );
endinterface

// File: rtl/decommutator_rr_lane_select.sv
// Rotating-priority pick of a full lane starting at i_ptr; combinational, no backpressure.
// SKIP_EMPTY=0 always picks i_ptr and reports whether that lane is full.
module rr_lane_select #(
    parameter int NUM_CH     = 4,
    parameter int SKIP_EMPTY = 0
) (
    input  logic [NUM_CH-1:0]         i_hold_full,
    input  logic [$clog2(NUM_CH)-1:0] i_ptr,
    output logic [$clog2(NUM_CH)-1:0] o_sel,
    output logic                      o_any
);
    localparam int CW = $clog2(NUM_CH);

    logic [CW-1:0] w_idx;

    always_comb begin
        w_idx = '0;
        o_sel = i_ptr;
        o_any = i_hold_full[i_ptr];
        if (SKIP_EMPTY != 0) begin
            o_any = |i_hold_full;
            // Scan farthest-first so the lane closest to i_ptr wins; wrap is free for power-of-two NUM_CH.
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                w_idx = i_ptr + CW'(k);
                if (i_hold_full[w_idx]) begin
                    o_sel = w_idx;
                end
            end
        end
    end
endmodule

// File: rtl/decommutator.sv
// Gathers NUM_CH lanes round-robin into one tagged serial stream; accept-to-out_valid 2 cycles, 1 word/cycle.
// Registered output holds while !out_ready; lane in_ready stays high on a lane drained this cycle (comb from out_ready).
module decommutator
    import commutator_pkg::*;
#(
    parameter int WIDTH      = COMM_WIDTH,
    parameter int NUM_CH     = COMM_NUM_CH,
    parameter int SKIP_EMPTY = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    decommutator_if.slave  bus
);
    localparam int CW = $clog2(NUM_CH);

    logic [NUM_CH-1:0] r_hold_full;
    logic [WIDTH-1:0]  r_hold_data [NUM_CH];
    logic [CW-1:0]     r_ptr;
    logic [WIDTH-1:0]  r_out_data;
    logic [CW-1:0]     r_out_chan;
    logic              r_out_last;
    logic              r_out_valid;

    logic [CW-1:0]     w_sel;
    logic              w_any;
    logic              w_out_free;
    logic              w_load;
    logic [NUM_CH-1:0] w_drain;
    logic [NUM_CH-1:0] w_in_ready;
    logic [NUM_CH-1:0] w_accept;

    rr_lane_select #(
        .NUM_CH     (NUM_CH),
        .SKIP_EMPTY (SKIP_EMPTY)
    ) u_sel (
        .i_hold_full (r_hold_full),
        .i_ptr       (r_ptr),
        .o_sel       (w_sel),
        .o_any       (w_any)
    );

    always_comb begin
        w_out_free = !r_out_valid || bus.out_ready;
        w_load     = w_out_free && w_any;
        w_drain    = '0;
        w_in_ready = '0;
        w_accept   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_drain[i]    = w_load && (w_sel == CW'(i));
            w_in_ready[i] = !r_hold_full[i] || w_drain[i];
            w_accept[i]   = bus.in_valid[i] && w_in_ready[i];
        end
    end

    // A refill in the drain cycle wins, so the lane stays full with the new word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_full <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_hold_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_accept[i]) begin
                    r_hold_full[i] <= 1'b1;
                    r_hold_data[i] <= bus.in_data[i];
                end else if (w_drain[i]) begin
                    r_hold_full[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_data  <= r_hold_data[w_sel];
            r_out_chan  <= w_sel;
            r_out_last  <= (w_sel == CW'(NUM_CH - 1));
            r_out_valid <= 1'b1;
            r_ptr       <= w_sel + CW'(1);
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_chan  = r_out_chan;
    assign bus.out_last  = r_out_last;
    assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_decommutator.sv
// Strict and skip-empty decommutators side by side, driven with random lane traffic
// and checked against per-lane word queues plus the round-robin ordering rules.
module tb_decommutator;
    import commutator_pkg::*;

    localparam int W  = COMM_WIDTH;
    localparam int N  = COMM_NUM_CH;
    localparam int CW = $clog2(N);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decommutator_if #(.WIDTH(W), .NUM_CH(N)) bus0 ();
    decommutator_if #(.WIDTH(W), .NUM_CH(N)) bus1 ();

    decommutator #(.WIDTH(W), .NUM_CH(N), .SKIP_EMPTY(0)) u_strict (
        .clk (clk), .rst_n (rst_n), .bus (bus0.slave)
    );
    decommutator #(.WIDTH(W), .NUM_CH(N), .SKIP_EMPTY(1)) u_skip (
        .clk (clk), .rst_n (rst_n), .bus (bus1.slave)
    );

    logic [W-1:0]  d_data  [2][N];
    logic [N-1:0]  d_valid [2];
    logic          d_ordy  [2];
    logic [N-1:0]  s_rdy   [2];
    logic [W-1:0]  s_dat   [2];
    logic [CW-1:0] s_ch    [2];
    logic          s_last  [2];
    logic          s_ov    [2];

    for (genvar g = 0; g < N; g++) begin : g_lane
        assign bus0.in_data[g] = d_data[0][g];
        assign bus1.in_data[g] = d_data[1][g];
    end
    assign bus0.in_valid  = d_valid[0];
    assign bus1.in_valid  = d_valid[1];
    assign bus0.out_ready = d_ordy[0];
    assign bus1.out_ready = d_ordy[1];
    assign s_rdy[0]  = bus0.in_ready;   assign s_rdy[1]  = bus1.in_ready;
    assign s_dat[0]  = bus0.out_data;   assign s_dat[1]  = bus1.out_data;
    assign s_ch[0]   = bus0.out_chan;   assign s_ch[1]   = bus1.out_chan;
    assign s_last[0] = bus0.out_last;   assign s_last[1] = bus1.out_last;
    assign s_ov[0]   = bus0.out_valid;  assign s_ov[1]   = bus1.out_valid;

    // Words accepted on a lane and not yet delivered downstream, oldest first.
    word_t        exp_q [2][N][$];
    int           exp_ch [2];
    int           xfers  [2];
    logic [N-1:0] acc    [2];
    logic         xfer   [2];
    logic         smp_ov [2];
    word_t        smp_dat[2];
    chan_t        smp_ch [2];
    logic         p_hold [2];
    word_t        p_dat  [2];
    chan_t        p_ch   [2];
    int           chk_cnt  = 0;
    int           pass_cnt = 0;

    function automatic int pending(int m);
        int s = 0;
        for (int i = 0; i < N; i++) s += exp_q[m][i].size();
        return s;
    endfunction

    task automatic clear_model();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < N; i++) exp_q[m][i].delete();
            exp_ch[m] = 0; xfers[m] = 0; acc[m] = '0; xfer[m] = 1'b0; p_hold[m] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int m = 0; m < 2; m++) begin
            d_valid[m] = '0; d_ordy[m] = 1'b0;
            for (int i = 0; i < N; i++) d_data[m][i] = '0;
        end
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Sample both DUTs at the falling edge, score what the next rising edge will commit.
    task automatic step();
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            int    c;
            word_t w;
            acc[m] = '0; xfer[m] = 1'b0;
            smp_ov[m] = s_ov[m]; smp_dat[m] = s_dat[m]; smp_ch[m] = s_ch[m];
            if (p_hold[m]) begin
                chk_cnt++;
                if (s_ov[m] !== 1'b1 || s_dat[m] !== p_dat[m] || s_ch[m] !== p_ch[m])
                    $display("FAIL hold_stable dut%0d: valid=%b data=%h chan=%0d, required valid=1 data=%h chan=%0d",
                             m, s_ov[m], s_dat[m], s_ch[m], p_dat[m], p_ch[m]);
                else pass_cnt++;
            end
            for (int i = 0; i < N; i++) begin
                int   fly;
                logic exp_rdy;
                fly = exp_q[m][i].size() - ((s_ov[m] === 1'b1 && int'(s_ch[m]) == i) ? 1 : 0);
                exp_rdy = (fly == 0);
                if (m == 0)
                    exp_rdy = exp_rdy || ((!s_ov[m] || d_ordy[m]) &&
                              ((exp_ch[0] + (s_ov[m] ? 1 : 0)) % N) == i);
                if (m == 0 || (s_ov[m] && !d_ordy[m])) begin
                    chk_cnt++;
                    if (s_rdy[m][i] !== exp_rdy)
                        $display("FAIL in_ready dut%0d lane%0d: got %b, required %b", m, i, s_rdy[m][i], exp_rdy);
                    else pass_cnt++;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (d_valid[m][i] && s_rdy[m][i]) begin
                    acc[m][i] = 1'b1;
                    exp_q[m][i].push_back(d_data[m][i]);
                end
            end
            if (s_ov[m] === 1'b1 && d_ordy[m]) begin
                xfer[m] = 1'b1; xfers[m]++;
                c = int'(s_ch[m]);
                if (m == 0) begin
                    chk_cnt++;
                    if (c != exp_ch[0] || s_last[0] !== (exp_ch[0] == N - 1))
                        $display("FAIL strict_order: chan=%0d last=%b, required chan=%0d last=%b",
                                 c, s_last[0], exp_ch[0], (exp_ch[0] == N - 1));
                    else pass_cnt++;
                    exp_ch[0] = (exp_ch[0] + 1) % N;
                end
                chk_cnt++;
                if (exp_q[m][c].size() == 0) begin
                    $display("FAIL out_word dut%0d: got %h on lane %0d, required no word (lane empty)", m, s_dat[m], c);
                end else begin
                    w = exp_q[m][c].pop_front();
                    if (s_dat[m] !== w)
                        $display("FAIL out_word dut%0d lane%0d: got %h, required %h", m, c, s_dat[m], w);
                    else pass_cnt++;
                end
            end
            p_hold[m] = (s_ov[m] === 1'b1) && !d_ordy[m];
            p_dat[m]  = s_dat[m];
            p_ch[m]   = s_ch[m];
        end
        @(posedge clk);
        #1;
    endtask

    // Lanes whose word was taken (or that are idle) get a fresh valid/data decision.
    task automatic refresh(int m, logic [N-1:0] en, int pct, int mode);
        for (int i = 0; i < N; i++) begin
            if (!d_valid[m][i] || acc[m][i]) begin
                d_valid[m][i] = en[i] && ($urandom_range(99) < pct);
                case (mode)
                    1:       d_data[m][i] = W'(16'h00A0 + i);
                    2:       d_data[m][i] = W'(16'h0011 * i);
                    3:       d_data[m][i] = W'(16'h00B0 + i);
                    default: d_data[m][i] = W'($urandom);
                endcase
            end
        end
    endtask

    task automatic drain(int m);
        d_valid[m] = '0;
        d_ordy[m]  = 1'b1;
        repeat (12) step();
        chk_cnt++;
        if (m == 1) begin
            if (pending(1) != 0)
                $display("FAIL drain_skip: %0d words left, required 0", pending(1));
            else pass_cnt++;
        end else begin
            if (exp_q[0][exp_ch[0]].size() != 0 || smp_ov[0] !== 1'b0)
                $display("FAIL drain_strict: lane %0d holds %0d words out_valid=%b, required 0 words and 0",
                         exp_ch[0], exp_q[0][exp_ch[0]].size(), smp_ov[0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int m = 0; m < 2; m++) begin
            d_valid[m] = '1; d_ordy[m] = 1'b1;
            for (int i = 0; i < N; i++) d_data[m][i] = W'($urandom);
        end
        #12;
        for (int m = 0; m < 2; m++) begin
            chk_cnt++;
            if (s_ov[m] !== 1'b0 || s_dat[m] !== '0 || s_ch[m] !== '0 || s_last[m] !== 1'b0)
                $display("FAIL reset_out dut%0d: valid=%b data=%h chan=%0d last=%b, required all 0",
                         m, s_ov[m], s_dat[m], s_ch[m], s_last[m]);
            else pass_cnt++;
            chk_cnt++;
            if (s_rdy[m] !== {N{1'b1}})
                $display("FAIL reset_ready dut%0d: got %b, required all ones", m, s_rdy[m]);
            else pass_cnt++;
        end
    endtask

    task automatic test_fill();
        do_reset();
        d_ordy[0] = 1'b1;
        for (int k = 0; k < 14; k++) begin
            refresh(0, '1, 100, 1);
            step();
            chk_cnt++;
            if (smp_ov[0] !== (k >= 2))
                $display("FAIL fill_latency cycle%0d: out_valid=%b, required %b", k, smp_ov[0], (k >= 2));
            else pass_cnt++;
        end
        drain(0);
    endtask

    task automatic test_stall_lane2();
        do_reset();
        d_ordy[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            refresh(0, 4'b1011, 100, 0);
            step();
        end
        chk_cnt++;
        if (xfers[0] != 2 || smp_ov[0] !== 1'b0)
            $display("FAIL stall_lane2: words=%0d out_valid=%b, required 2 and 0", xfers[0], smp_ov[0]);
        else pass_cnt++;
        d_valid[0][2] = 1'b1;
        d_data[0][2]  = 16'h0022;
        for (int k = 0; k < 8; k++) begin
            refresh(0, 4'b1011, 100, 0);
            step();
        end
        chk_cnt++;
        if (xfers[0] < 4)
            $display("FAIL stall_resume: words=%0d, required at least 4", xfers[0]);
        else pass_cnt++;
        drain(0);
    endtask

    task automatic test_skip();
        chan_t exp_alt = chan_t'(1);
        logic  started = 1'b0;
        do_reset();
        d_ordy[1] = 1'b1;
        for (int k = 0; k < 14; k++) begin
            refresh(1, 4'b1010, 100, 2);
            step();
            if (started) begin
                chk_cnt++;
                if (smp_ov[1] !== 1'b1)
                    $display("FAIL skip_bubble cycle%0d: out_valid=%b, required 1", k, smp_ov[1]);
                else pass_cnt++;
            end
            if (smp_ov[1] === 1'b1) begin
                chk_cnt++;
                if (smp_ch[1] !== exp_alt)
                    $display("FAIL skip_order cycle%0d: chan=%0d, required %0d", k, smp_ch[1], exp_alt);
                else pass_cnt++;
                exp_alt = (exp_alt == chan_t'(1)) ? chan_t'(3) : chan_t'(1);
                started = 1'b1;
            end
        end
        drain(1);
    endtask

    task automatic test_backpressure();
        for (int m = 0; m < 2; m++) begin
            do_reset();
            for (int k = 0; k < 150; k++) begin
                d_ordy[m] = ((k % 10) >= 6) ? 1'b0 : ($urandom_range(3) != 0);
                refresh(m, '1, 60, 0);
                step();
            end
            drain(m);
            chk_cnt++;
            if (xfers[m] < 20)
                $display("FAIL bp_progress dut%0d: words=%0d, required at least 20", m, xfers[m]);
            else pass_cnt++;
        end
    endtask

    task automatic test_drain_refill();
        do_reset();
        d_ordy[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            refresh(0, '1, 100, 0);
            step();
        end
        chk_cnt++;
        if (xfers[0] != 18)
            $display("FAIL drain_refill_rate: words=%0d, required 18", xfers[0]);
        else pass_cnt++;
        drain(0);
    endtask

    task automatic test_reset_mid();
        logic first = 1'b1;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            refresh(0, '1, 100, 0);
            step();
        end
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (s_ov[0] !== 1'b0 || s_dat[0] !== '0 || s_ch[0] !== '0 || s_last[0] !== 1'b0)
            $display("FAIL midreset_out: valid=%b data=%h chan=%0d last=%b, required all 0",
                     s_ov[0], s_dat[0], s_ch[0], s_last[0]);
        else pass_cnt++;
        chk_cnt++;
        if (s_rdy[0] !== {N{1'b1}})
            $display("FAIL midreset_ready: got %b, required all ones", s_rdy[0]);
        else pass_cnt++;
        clear_model();
        for (int i = 0; i < N; i++) d_data[0][i] = W'(16'h00B0 + i);
        d_valid[0] = '1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        d_ordy[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            if (xfer[0] && first) begin
                chk_cnt++;
                if (smp_ch[0] !== '0 || smp_dat[0] !== 16'h00B0)
                    $display("FAIL midreset_first: chan=%0d data=%h, required 0 and 00b0", smp_ch[0], smp_dat[0]);
                else pass_cnt++;
                first = 1'b0;
            end
            refresh(0, '1, 100, 3);
        end
        chk_cnt++;
        if (first)
            $display("FAIL midreset_timeout: got no output word, required one within 8 cycles");
        else pass_cnt++;
        drain(0);
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stall_lane2();
        test_skip();
        test_backpressure();
        test_drain_refill();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
